gerenciador_ativos: RTL

GERENCIADOR_ATIVOS -- requirements
Module: gerenciador_ativos

---
 rtl/gerenciador_ativos.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gerenciador_ativos.sv
// rtl/gerenciador_ativos.sv - active-node slot manager: finds match/free slot and emits one-hot slot commands
module gerenciador_ativos #(
    parameter int ADDR_WIDTH      = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CRITERIO_WIDTH  = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int NUM_NOS         = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid_in,
    input  logic                           req_op_in,
    input  logic [ADDR_WIDTH-1:0]          req_endereco_in,
    input  logic [DISTANCIA_WIDTH-1:0]     req_distancia_in,
    input  logic [ADDR_WIDTH-1:0]          req_anterior_in,
    input  logic [CUSTO_WIDTH-1:0]         req_menor_vizinho_in,
    input  logic [NUM_NOS-1:0]             na_ativo_in,
    input  logic [NUM_NOS*ADDR_WIDTH-1:0]  na_endereco_in,
    input  logic [NUM_NOS*CRITERIO_WIDTH-1:0] na_criterio_in,
    output logic                           req_ready_out,
    output logic [NUM_NOS-1:0]             ga_habilitar_out,
    output logic                           atualizar_out,
    output logic                           desativar_out,
    output logic [ADDR_WIDTH-1:0]          endereco_out,
    output logic [ADDR_WIDTH-1:0]          anterior_out,
    output logic [DISTANCIA_WIDTH-1:0]     distancia_out,
    output logic [CUSTO_WIDTH-1:0]         menor_vizinho_out,
    output logic [CRITERIO_WIDTH-1:0]      ca_criterio_geral_out,
    output logic                           ga_cheio_out,
    output logic                           ga_vazio_out,
    output logic                           ga_erro_out
);

    typedef enum logic [1:0] {IDLE, BUSCA, EMITIR, ESPERA} estado_t;

    estado_t                   estado;
    logic                      op_q;
    logic [NUM_NOS-1:0]        match_oh;
    logic [NUM_NOS-1:0]        free_oh;
    logic [NUM_NOS-1:0]        target_oh;
    logic                      match_found;
    logic                      free_found;
    logic                      has_target;
    logic [CRITERIO_WIDTH-1:0] crit_min;

    // Priority search: lowest slot index wins for both match and free slot.
    always_comb begin
        match_oh    = '0;
        free_oh     = '0;
        match_found = 1'b0;
        free_found  = 1'b0;
        crit_min    = '1;
        for (int i = 0; i < NUM_NOS; i++) begin
            if (!match_found && na_ativo_in[i] &&
                na_endereco_in[i*ADDR_WIDTH +: ADDR_WIDTH] == endereco_out) begin
                match_oh[i] = 1'b1;
                match_found = 1'b1;
            end
            if (!free_found && !na_ativo_in[i]) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
            if (na_ativo_in[i] && na_criterio_in[i*CRITERIO_WIDTH +: CRITERIO_WIDTH] < crit_min)
                crit_min = na_criterio_in[i*CRITERIO_WIDTH +: CRITERIO_WIDTH];
        end
    end

    always_comb begin
        if (op_q || match_found)
            target_oh = match_oh;
        else
            target_oh = free_oh;
        has_target = |target_oh;
    end

    // The captured request registers double as the broadcast operand outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado            <= IDLE;
            req_ready_out     <= 1'b1;
            op_q              <= 1'b0;
            endereco_out      <= '0;
            anterior_out      <= '0;
            distancia_out     <= '0;
            menor_vizinho_out <= '0;
            ga_habilitar_out  <= '0;
            atualizar_out     <= 1'b0;
            desativar_out     <= 1'b0;
            ga_erro_out       <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (req_valid_in) begin
                        op_q              <= req_op_in;
                        endereco_out      <= req_endereco_in;
                        anterior_out      <= req_anterior_in;
                        distancia_out     <= req_distancia_in;
                        menor_vizinho_out <= req_menor_vizinho_in;
                        req_ready_out     <= 1'b0;
                        estado            <= BUSCA;
                    end
                end
                BUSCA: begin
                    ga_habilitar_out <= target_oh;
                    atualizar_out    <= has_target && !op_q;
                    desativar_out    <= has_target && op_q;
                    ga_erro_out      <= !has_target;
                    estado           <= EMITIR;
                end
                EMITIR: begin
                    ga_habilitar_out <= '0;
                    atualizar_out    <= 1'b0;
                    desativar_out    <= 1'b0;
                    ga_erro_out      <= 1'b0;
                    estado           <= ESPERA;
                end
                ESPERA: begin
                    req_ready_out <= 1'b1;
                    estado        <= IDLE;
                end
                default: begin
                    req_ready_out <= 1'b1;
                    estado        <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_criterio_geral_out <= '1;
            ga_cheio_out          <= 1'b0;
            ga_vazio_out          <= 1'b1;
        end else begin
            ca_criterio_geral_out <= crit_min;
            ga_cheio_out          <= &na_ativo_in;
            ga_vazio_out          <= ~|na_ativo_in;
        end
    end

endmodule
